// File: rtl/alsu_core.sv
// Registered 3-bit arithmetic/logic/shift unit with a 16-bit LED alarm bus.
// Define ALSU_INVALID_FLAG_EN to add the registered `invalid` output.
module alsu_core #(
    parameter string Priority = "A",
    parameter string Adder    = "ON"
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    input  logic        cin,
    input  logic        serial,
    input  logic        direction,
    input  logic        op_A,
    input  logic        op_B,
    input  logic [2:0]  opcode,
    input  logic        bypass_A,
    input  logic        bypass_B,
    output logic [15:0] leds,
`ifdef ALSU_INVALID_FLAG_EN
    output logic [5:0]  out,
    output logic        invalid
`else
    output logic [5:0]  out
`endif
);

    localparam bit PRIO_A   = (Priority == "A");
    localparam bit ADD_FULL = (Adder == "ON");

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_SHF = 3'd4;
    localparam logic [2:0] OP_ROT = 3'd5;

    logic [2:0] a_r;
    logic [2:0] b_r;
    logic       cin_r;
    logic       serial_r;
    logic       dir_r;
    logic       op_a_r;
    logic       op_b_r;
    logic [2:0] opcode_r;
    logic       byp_a_r;
    logic       byp_b_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r      <= '0;
            b_r      <= '0;
            cin_r    <= 1'b0;
            serial_r <= 1'b0;
            dir_r    <= 1'b0;
            op_a_r   <= 1'b0;
            op_b_r   <= 1'b0;
            opcode_r <= '0;
            byp_a_r  <= 1'b0;
            byp_b_r  <= 1'b0;
        end else begin
            a_r      <= A;
            b_r      <= B;
            cin_r    <= cin;
            serial_r <= serial;
            dir_r    <= direction;
            op_a_r   <= op_A;
            op_b_r   <= op_B;
            opcode_r <= opcode;
            byp_a_r  <= bypass_A;
            byp_b_r  <= bypass_B;
        end
    end

    logic bad_op;
    logic sel_byp;
    logic sel_inv;
    logic sel_op;

    assign bad_op  = (&opcode_r[2:1])
                   | ((op_a_r | op_b_r) & (|opcode_r[2:1]));
    assign sel_byp = byp_a_r | byp_b_r;
    assign sel_inv = ~sel_byp & bad_op;
    assign sel_op  = ~sel_byp & ~bad_op;

    // Reduction targets one operand; Priority breaks the tie
    logic red_a;
    logic red_b;

    assign red_a = op_a_r & (~op_b_r | PRIO_A);
    assign red_b = op_b_r & (~op_a_r | ~PRIO_A);

    logic [2:0] byp_val;

    always_comb begin
        byp_val = b_r;
        if (byp_a_r & (~byp_b_r | PRIO_A))
            byp_val = a_r;
    end

    logic [5:0] op_val;
    logic [5:0] sum;
    logic [5:0] prod;

    assign sum  = {3'b000, a_r} + {3'b000, b_r}
                + {5'b00000, cin_r & ADD_FULL};
    assign prod = {3'b000, a_r} * {3'b000, b_r};

    always_comb begin
        op_val = '0;
        unique case (opcode_r)
            OP_AND: begin
                unique case (1'b1)
                    red_a:   op_val = {5'b0, &a_r};
                    red_b:   op_val = {5'b0, &b_r};
                    default: op_val = {3'b0, a_r & b_r};
                endcase
            end
            OP_XOR: begin
                unique case (1'b1)
                    red_a:   op_val = {5'b0, ^a_r};
                    red_b:   op_val = {5'b0, ^b_r};
                    default: op_val = {3'b0, a_r ^ b_r};
                endcase
            end
            OP_ADD: op_val = sum;
            OP_MUL: op_val = prod;
            OP_SHF: op_val = dir_r ? {out[4:0], serial_r}
                                   : {serial_r, out[5:1]};
            OP_ROT: op_val = dir_r ? {out[4:0], out[5]}
                                   : {out[0], out[5:1]};
            default: op_val = '0;
        endcase
    end

    logic [5:0]  out_nxt;
    logic [15:0] leds_nxt;
    logic        inv_nxt;

    always_comb begin
        out_nxt  = '0;
        leds_nxt = '0;
        inv_nxt  = 1'b0;
        unique case (1'b1)
            sel_byp: out_nxt = {3'b000, byp_val};
            sel_inv: begin
                leds_nxt = ~leds;
                inv_nxt  = 1'b1;
            end
            sel_op:  out_nxt = op_val;
            default: out_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out  <= '0;
            leds <= '0;
        end else begin
            out  <= out_nxt;
            leds <= leds_nxt;
        end
    end

`ifdef ALSU_INVALID_FLAG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            invalid <= 1'b0;
        else
            invalid <= inv_nxt;
    end
`else
    logic unused_inv;
    assign unused_inv = inv_nxt;
`endif

endmodule

// File: tb/tb_alsu_core.sv
// Bench for alsu_core: two instances (Priority A/Adder ON, Priority B/Adder OFF)
// share stimulus and are compared against an arithmetic reference model.
module tb_alsu_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  A, B, opcode;
    logic        cin, serial, direction;
    logic        op_A, op_B, bypass_A, bypass_B;
    logic [15:0] leds1, leds2;
    logic [5:0]  out1, out2;
    logic        inv1, inv2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alsu_core #(.Priority("A"), .Adder("ON")) dut1 (
        .clk(clk), .rstn(rstn), .A(A), .B(B), .cin(cin),
        .serial(serial), .direction(direction),
        .op_A(op_A), .op_B(op_B), .opcode(opcode),
        .bypass_A(bypass_A), .bypass_B(bypass_B),
        .leds(leds1),
`ifdef ALSU_INVALID_FLAG_EN
        .out(out1), .invalid(inv1)
`else
        .out(out1)
`endif
    );

    alsu_core #(.Priority("B"), .Adder("OFF")) dut2 (
        .clk(clk), .rstn(rstn), .A(A), .B(B), .cin(cin),
        .serial(serial), .direction(direction),
        .op_A(op_A), .op_B(op_B), .opcode(opcode),
        .bypass_A(bypass_A), .bypass_B(bypass_B),
        .leds(leds2),
`ifdef ALSU_INVALID_FLAG_EN
        .out(out2), .invalid(inv2)
`else
        .out(out2)
`endif
    );

`ifndef ALSU_INVALID_FLAG_EN
    assign inv1 = 1'b0;
    assign inv2 = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] a, b;
        logic       cin, serial, dir, op_a, op_b;
        logic [2:0] opcode;
        logic       byp_a, byp_b;
    } smp_t;

    typedef struct packed {
        logic [5:0]  out;
        logic [15:0] leds;
        logic        inv;
    } st_t;

    smp_t prev;
    st_t  st1, st2;

    // Reference: the unit's rules evaluated on one latched sample
    function automatic st_t next_st(bit prio_a, bit add_on, smp_t s, st_t c);
        st_t n;
        int  x, o;
        bit  bad, ra, rb;
        o = int'(c.out);
        x = 0;
        n.leds = 16'h0000;
        n.inv  = 1'b0;
        bad = (s.opcode >= 6) || ((s.op_a || s.op_b) && s.opcode > 1);
        ra = s.op_a && (!s.op_b || prio_a);
        rb = s.op_b && (!s.op_a || !prio_a);
        if (s.byp_a || s.byp_b) begin
            if (s.byp_a && s.byp_b) x = prio_a ? int'(s.a) : int'(s.b);
            else x = s.byp_a ? int'(s.a) : int'(s.b);
        end else if (bad) begin
            x = 0;
            n.leds = ~c.leds;
            n.inv  = 1'b1;
        end else begin
            case (s.opcode)
                0: x = ra ? int'(s.a == 7) : rb ? int'(s.b == 7)
                          : int'(s.a & s.b);
                1: x = ra ? $countones(s.a) % 2 : rb ? $countones(s.b) % 2
                          : int'(s.a ^ s.b);
                2: x = int'(s.a) + int'(s.b) + (add_on ? int'(s.cin) : 0);
                3: x = int'(s.a) * int'(s.b);
                4: x = s.dir ? (o * 2 + int'(s.serial)) % 64
                             : o / 2 + int'(s.serial) * 32;
                5: x = s.dir ? (o * 2) % 64 + o / 32
                             : o / 2 + (o % 2) * 32;
                default: x = 0;
            endcase
        end
        n.out = 6'(x);
        return n;
    endfunction

    function automatic smp_t cur();
        smp_t s;
        s.a = A; s.b = B; s.cin = cin; s.serial = serial;
        s.dir = direction; s.op_a = op_A; s.op_b = op_B;
        s.opcode = opcode; s.byp_a = bypass_A; s.byp_b = bypass_B;
        return s;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("out1", {10'b0, out1}, {10'b0, st1.out});
        check("leds1", leds1, st1.leds);
        check("out2", {10'b0, out2}, {10'b0, st2.out});
        check("leds2", leds2, st2.leds);
`ifdef ALSU_INVALID_FLAG_EN
        check("inv1", {15'b0, inv1}, {15'b0, st1.inv});
        check("inv2", {15'b0, inv2}, {15'b0, st2.inv});
`endif
    endtask

    task automatic step();
        @(posedge clk);
        st1  = next_st(1'b1, 1'b1, prev, st1);
        st2  = next_st(1'b0, 1'b0, prev, st2);
        prev = cur();
        #1;
        check_model();
    endtask

    task automatic clear_in();
        A = 0; B = 0; cin = 0; serial = 0; direction = 0;
        op_A = 0; op_B = 0; opcode = 0; bypass_A = 0; bypass_B = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        st1  = '0;
        st2  = '0;
        prev = '0;
        check("rst_out1", {10'b0, out1}, 16'h0);
        check("rst_leds1", leds1, 16'h0);
        check("rst_out2", {10'b0, out2}, 16'h0);
        check("rst_leds2", leds2, 16'h0);
    endtask

    task automatic rand_in();
        A = 3'($urandom); B = 3'($urandom);
        cin = 1'($urandom); serial = 1'($urandom);
        direction = 1'($urandom);
        opcode = 3'($urandom);
        op_A = ($urandom_range(3) == 0);
        op_B = ($urandom_range(3) == 0);
        bypass_A = ($urandom_range(7) == 0);
        bypass_B = ($urandom_range(7) == 0);
    endtask

    initial begin
        clear_in();
        rand_in();
        rstn = 1'b0;
        #23;
        do_reset();
        @(posedge clk);
        #1;
        clear_in();
        rstn = 1'b1;
        step();
        step();
        check("zero_and", {10'b0, out1}, 16'd0);

        bypass_A = 1; bypass_B = 1; A = 5; B = 2; opcode = 7;
        step();
        step();
        check("byp_prioA", {10'b0, out1}, 16'd5);
        check("byp_prioB", {10'b0, out2}, 16'd2);
        check("byp_leds", leds1, 16'h0);

        bypass_A = 0; bypass_B = 0; A = 3;
        step();
        step();
        check("blink_on", leds1, 16'hFFFF);
        check("blink_out", {10'b0, out1}, 16'd0);
        step();
        check("blink_off", leds1, 16'h0000);
        step();
        check("blink_on2", leds2, 16'hFFFF);
        do_reset();
        clear_in();
        rstn = 1'b1;

        opcode = 2; op_A = 1;
        step();
        step();
        check("inv_add_on", leds1, 16'hFFFF);
        step();
        check("inv_add_off", leds1, 16'h0000);
        check("inv_add_out", {10'b0, out1}, 16'd0);

        op_A = 0; opcode = 0; A = 6; B = 3;
        step();
        step();
        check("exit_leds", leds1, 16'h0);
        check("and_bitwise", {10'b0, out1}, 16'd2);
        op_A = 1; A = 7;
        step();
        step();
        check("and_redA", {10'b0, out1}, 16'd1);
        op_A = 0; opcode = 1; op_B = 1; B = 3;
        step();
        step();
        check("xor_redB", {10'b0, out1}, 16'd0);
        op_A = 1; A = 1;
        step();
        step();
        check("xor_prioA", {10'b0, out1}, 16'd1);
        check("xor_prioB", {10'b0, out2}, 16'd0);

        op_A = 0; op_B = 0; opcode = 2; A = 7; B = 7; cin = 1;
        step();
        step();
        check("add_full", {10'b0, out1}, 16'd15);
        check("add_half", {10'b0, out2}, 16'd14);
        opcode = 3; B = 6;
        step();
        step();
        check("mult", {10'b0, out1}, 16'd42);

        opcode = 4; direction = 1;
        foreach (prev.a[i]) begin end
        for (int i = 5; i >= 0; i--) begin
            serial = 1'((6'b101100 >> i) & 6'd1);
            step();
        end
        serial = 1;
        step();
        check("preload", {10'b0, out1}, 16'h2C);
        opcode = 5; direction = 0;
        step();
        check("shift_l", {10'b0, out1}, 16'h19);
        direction = 1;
        step();
        check("rot_r", {10'b0, out1}, 16'h2C);
        opcode = 0;
        step();
        check("rot_l", {10'b0, out1}, 16'h19);

        for (int i = 0; i < 600; i++) begin
            rand_in();
            if ($urandom_range(63) == 0) begin
                do_reset();
                rstn = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
